// File: rtl/adc_lvds_tx_emulator_pkg.sv
// Shared types and helpers for the ADC LVDS transmit emulator: link states,
// default frame/sync patterns and the serial-delay word function.
package adc_lvds_tx_emulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_TRAIN  = 3'b010,
        ST_STREAM = 3'b100
    } state_t;

    localparam logic [7:0] FCO_PATTERN_DEF  = 8'hF0;
    localparam logic [7:0] SYNC_PATTERN_DEF = 8'hF0;

    // Delaying a serial stream by r bits is equivalent to taking the word
    // straddling the previous and current parallel words: {P[r-1:0], C[7:r]}.
    function automatic logic [7:0] rot_word(input logic [7:0] prev,
                                            input logic [7:0] curr,
                                            input logic [2:0] r);
        logic [15:0] cat;
        cat = {prev, curr} >> r;
        return cat[7:0];
    endfunction

endpackage

// File: rtl/adc_lvds_tx_emulator_if.sv
// Control, sample-handshake and OSERDES-word signals of the LVDS transmit
// emulator; master is the sample source/controller, slave is the emulator.
interface adc_lvds_tx_emulator_if #(
    parameter int LANES   = 2,
    parameter int UFLOW_W = 16
);
    logic                 en;
    logic [15:0]          train_frames;
    logic [2:0]           rot;
    logic                 rot_load;
    logic [LANES*8-1:0]   s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [7:0]           fco_word;
    logic [LANES*8-1:0]   lane_word;
    logic                 training;
    logic                 streaming;
    logic                 underflow;
    logic [UFLOW_W-1:0]   uflow_cnt;

    modport master (
        output en, train_frames, rot, rot_load, s_data, s_valid,
        input  s_ready, fco_word, lane_word, training, streaming, underflow, uflow_cnt
    );

    modport slave (
        input  en, train_frames, rot, rot_load, s_data, s_valid,
        output s_ready, fco_word, lane_word, training, streaming, underflow, uflow_cnt
    );
endinterface

// File: rtl/adc_lvds_tx_emulator_word_rotator.sv
// One serial stream's delay stage: keeps the previous raw word and registers
// the r-bit delayed output word. hold repeats the previous raw word.
module word_rotator
    import adc_lvds_tx_emulator_pkg::*;
(
    input  logic       CLKDIV,
    input  logic       rst,
    input  logic [7:0] raw,
    input  logic       hold,
    input  logic [2:0] r,
    output logic [7:0] word
);
    logic [7:0] prev;
    logic [7:0] curr;

    assign curr = hold ? prev : raw;

    always_ff @(posedge CLKDIV) begin
        if (rst) begin
            prev <= 8'h00;
            word <= 8'h00;
        end else begin
            prev <= curr;
            word <= rot_word(prev, curr, r);
        end
    end

endmodule

// File: rtl/adc_lvds_tx_emulator.sv
// Transmit-side ADC LVDS link model: training/stream sequencing, underflow
// accounting and a shared programmable bit delay on FCO and all data lanes.
//
//  state     | meaning
//  ST_IDLE   | link off; FCO runs, lanes send 0
//  ST_TRAIN  | lanes send sync pattern for train_frames cycles
//  ST_STREAM | lanes carry samples; missing samples repeat last word
module adc_lvds_tx_emulator
    import adc_lvds_tx_emulator_pkg::*;
#(
    parameter int         LANES        = 2,
    parameter logic [7:0] FCO_PATTERN  = FCO_PATTERN_DEF,
    parameter logic [7:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
    parameter int         UFLOW_W      = 16
) (
    input  logic                   CLKDIV,
    input  logic                   rst,
    adc_lvds_tx_emulator_if.slave  bus
);
    state_t               state;
    logic [15:0]          train_cnt;
    logic [2:0]           r_q;
    logic                 training_q;
    logic                 streaming_q;
    logic                 underflow_q;
    logic [UFLOW_W-1:0]   uflow_cnt_q;
    logic [LANES*8-1:0]   raw_lanes;
    logic                 hold;
    logic                 starve;
    logic [7:0]           fco_word_q;
    logic [LANES*8-1:0]   lane_word_q;

    assign starve = (state == ST_STREAM) && !bus.s_valid;

    always_ff @(posedge CLKDIV) begin
        if (rst) begin
            state       <= ST_IDLE;
            train_cnt   <= 16'd0;
            r_q         <= 3'd0;
            training_q  <= 1'b0;
            streaming_q <= 1'b0;
            underflow_q <= 1'b0;
            uflow_cnt_q <= '0;
        end else begin
            if (bus.rot_load)
                r_q <= bus.rot;

            // Flags describe the word being registered this edge, so they
            // follow the state that produced it rather than the next state.
            training_q  <= (state == ST_TRAIN);
            streaming_q <= (state == ST_STREAM);
            underflow_q <= starve;
            if (starve && (uflow_cnt_q != '1))
                uflow_cnt_q <= uflow_cnt_q + UFLOW_W'(1);

            if (!bus.en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.train_frames == 16'd0) begin
                            state <= ST_STREAM;
                        end else begin
                            state     <= ST_TRAIN;
                            train_cnt <= bus.train_frames;
                        end
                    end
                    ST_TRAIN: begin
                        train_cnt <= train_cnt - 16'd1;
                        if (train_cnt == 16'd1)
                            state <= ST_STREAM;
                    end
                    ST_STREAM: state <= ST_STREAM;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        raw_lanes = '0;
        hold      = 1'b0;
        case (state)
            ST_TRAIN:  raw_lanes = {LANES{SYNC_PATTERN}};
            ST_STREAM: begin
                if (bus.s_valid)
                    raw_lanes = bus.s_data;
                else
                    hold = 1'b1;
            end
            default:   raw_lanes = '0;
        endcase
    end

    word_rotator u_fco_rot (
        .CLKDIV (CLKDIV),
        .rst    (rst),
        .raw    (FCO_PATTERN),
        .hold   (1'b0),
        .r      (r_q),
        .word   (fco_word_q)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        word_rotator u_lane_rot (
            .CLKDIV (CLKDIV),
            .rst    (rst),
            .raw    (raw_lanes[g*8 +: 8]),
            .hold   (hold),
            .r      (r_q),
            .word   (lane_word_q[g*8 +: 8])
        );
    end

    assign bus.s_ready   = (state == ST_STREAM);
    assign bus.fco_word  = fco_word_q;
    assign bus.lane_word = lane_word_q;
    assign bus.training  = training_q;
    assign bus.streaming = streaming_q;
    assign bus.underflow = underflow_q;
    assign bus.uflow_cnt = uflow_cnt_q;

endmodule

// File: tb/tb_adc_lvds_tx_emulator.sv
// Bench for adc_lvds_tx_emulator: directed scenarios with literal expectations
// plus a per-cycle comparison against a word-history model of the link.
module tb_adc_lvds_tx_emulator;
    localparam int LANES = 2;
    localparam int UW    = 4;
    localparam int UMAX  = (1 << UW) - 1;

    logic CLKDIV = 1'b0;
    logic rst    = 1'b1;
    always #5 CLKDIV = ~CLKDIV;

    adc_lvds_tx_emulator_if #(.LANES(LANES), .UFLOW_W(UW)) bus ();
    adc_lvds_tx_emulator #(.LANES(LANES), .UFLOW_W(UW)) dut (
        .CLKDIV (CLKDIV),
        .rst    (rst),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLKDIV);
    endtask

    // Model: link phase (0 off, 1 training, 2 streaming), raw word history per stream.
    function automatic int delay_word(input int p, input int c, input int r);
        return ((p * 256 + c) >> r) & 255;
    endfunction

    int         ph, left, r_m, prev_f, c_w, e_cnt;
    int         prev_l [LANES];
    logic [7:0]  e_fco;
    logic [15:0] e_lane;
    bit         e_tr, e_st, e_uf, model_ok;

    always @(posedge CLKDIV) begin
        if (rst) begin
            ph = 0; left = 0; r_m = 0; prev_f = 0; e_cnt = 0;
            for (int i = 0; i < LANES; i++) prev_l[i] = 0;
            e_fco = 0; e_lane = 0; e_tr = 0; e_st = 0; e_uf = 0;
            model_ok = 1;
        end else begin
            e_fco  = 8'(delay_word(prev_f, 'hF0, r_m));
            prev_f = 'hF0;
            for (int i = 0; i < LANES; i++) begin
                if (ph == 0)      c_w = 0;
                else if (ph == 1) c_w = 'hF0;
                else              c_w = bus.s_valid ? int'(bus.s_data[i*8 +: 8]) : prev_l[i];
                e_lane[i*8 +: 8] = 8'(delay_word(prev_l[i], c_w, r_m));
                prev_l[i] = c_w;
            end
            e_tr = (ph == 1);
            e_st = (ph == 2);
            e_uf = (ph == 2) && !bus.s_valid;
            if (e_uf && e_cnt < UMAX) e_cnt++;
            if (bus.rot_load) r_m = int'(bus.rot);
            if (!bus.en) ph = 0;
            else if (ph == 0) begin
                if (bus.train_frames == 0) ph = 2;
                else begin ph = 1; left = int'(bus.train_frames); end
            end else if (ph == 1) begin
                left--;
                if (left == 0) ph = 2;
            end
        end
    end

    always @(negedge CLKDIV) begin
        if (model_ok)
            check("per_cycle {fco,lane,tr,st,uf,rdy,cnt}",
                  {bus.fco_word, bus.lane_word, bus.training, bus.streaming, bus.underflow,
                   bus.s_ready, bus.uflow_cnt},
                  {e_fco, e_lane, e_tr, e_st, e_uf, (ph == 2), 4'(e_cnt)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int          tcount, uf, slip;
    logic [7:0]  vals [4];
    logic [7:0]  o    [4];
    logic [7:0]  f    [4];
    logic [15:0] w;

    initial begin
        bus.en = 0; bus.train_frames = 0; bus.rot = 0; bus.rot_load = 0;
        bus.s_data = 0; bus.s_valid = 0;
        vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'h96; vals[3] = 8'h5A;

        step(4);
        check("reset_fco", bus.fco_word, 8'h00);
        check("reset_lane", bus.lane_word, 16'h0000);
        rst = 0;
        step(1);
        check("idle_fco", bus.fco_word, 8'hF0);
        check("idle_lane", bus.lane_word, 16'h0000);
        check("idle_ready", bus.s_ready, 1'b0);

        bus.train_frames = 16'd5;
        bus.en = 1;
        tcount = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (bus.training) begin
                tcount++;
                check("train_lane", bus.lane_word, 16'hF0F0);
            end
            if (bus.streaming) break;
        end
        check("train_len", tcount, 5);
        check("stream_flag", bus.streaming, 1'b1);
        check("stream_ready", bus.s_ready, 1'b1);

        bus.s_valid = 1; bus.s_data = 16'h1234;
        step(1);
        check("data_1234", bus.lane_word, 16'h1234);
        bus.s_data = 16'h5678;
        step(1);
        check("data_5678", bus.lane_word, 16'h5678);

        bus.s_data = 16'hF0F0; bus.rot = 3'd3; bus.rot_load = 1;
        step(1);
        bus.rot_load = 0; bus.s_data = 16'h0F0F;
        step(1);
        check("rot3_fco", bus.fco_word, 8'h1E);
        check("rot3_lane0", bus.lane_word[7:0], 8'h01);
        for (int i = 0; i < 4; i++) begin
            bus.s_data = {vals[i], vals[i]};
            step(1);
            o[i] = bus.lane_word[7:0];
            f[i] = bus.fco_word;
        end
        slip = -1;
        for (int s = 7; s >= 0; s--) begin
            w = {f[2], f[3]} << s;
            if (w[15:8] == 8'hF0) slip = s;
        end
        check("aligner_slip", slip, 3);
        for (int i = 1; i < 4; i++) begin
            w = {o[i-1], o[i]} << slip;
            check("aligner_data", w[15:8], vals[i-1]);
        end
        bus.rot = 3'd0; bus.rot_load = 1;
        step(1);
        bus.rot_load = 0;

        bus.s_data = 16'hABCD;
        step(1);
        bus.s_valid = 0;
        uf = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (bus.underflow) uf++;
            check("hold_lane", bus.lane_word, 16'hABCD);
        end
        bus.s_valid = 1; bus.s_data = 16'h1111;
        step(1);
        if (bus.underflow) uf++;
        check("underflow_pulses", uf, 3);
        bus.s_valid = 0;
        step(20);
        check("uflow_saturate", bus.uflow_cnt, 4'hF);
        check("uflow_still_pulsing", bus.underflow, 1'b1);
        bus.s_valid = 1;

        bus.en = 0;
        step(1);
        check("en_drop_stream_ready", bus.s_ready, 1'b0);
        bus.train_frames = 16'd10; bus.en = 1;
        step(4);
        bus.en = 0;
        step(1);
        check("en_drop_train_ready", bus.s_ready, 1'b0);
        step(1);
        check("en_drop_train_flag", bus.training, 1'b0);
        check("en_drop_train_lane", bus.lane_word, 16'h0000);

        bus.train_frames = 16'd0; bus.en = 1;
        step(2);
        check("direct_stream", bus.streaming, 1'b1);
        bus.s_data = 16'h7777; bus.rot = 3'd5; bus.rot_load = 1;
        step(1);
        bus.rot_load = 0;
        step(2);
        rst = 1;
        step(1);
        check("rst_mid_fco", bus.fco_word, 8'h00);
        check("rst_mid_lane", bus.lane_word, 16'h0000);
        check("rst_mid_flags", {bus.s_ready, bus.streaming, bus.underflow}, 3'b000);
        check("rst_mid_cnt", bus.uflow_cnt, 4'h0);
        rst = 0; bus.en = 0;
        step(1);
        check("rot_cleared_fco", bus.fco_word, 8'hF0);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
